raster_engine: RTL and testbench
================================

RASTER_ENGINE -- requirements
Module: raster_engine

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  asynchronous active-high reset.
REQ-003 SHALL have port: command  input  2  opcode (00 CLEAR, 01 PIXEL, 10 LINE, 11 RECT).
REQ-004 SHALL have port: x1, y1, x2, y2  input  3 each  coordinates; x = column, y = row.
REQ-005 SHALL have port: rect_width, rect_height  input  3 each  RECT size in pixels.
REQ-006 SHALL have port: command_valid  input  1  one-cycle strobe qualifying all command inputs.
REQ-007 SHALL have port: fb_row_sel  input  3  framebuffer row read address.
REQ-008 SHALL have port: fb_row_data  output  8  combinational read of row fb_row_sel; bit[x] = pixel (x, row).
REQ-009 SHALL have port: busy  output  1  high while a command is executing.
REQ-010 SHALL have port: done  output  1  one-cycle pulse on command completion.

Function
REQ-011 SHALL hold an internal 8x8 framebuffer (64 bits); writes only set bits, except CLEAR.
REQ-012 SHALL use states IDLE, CLEAR, PIXEL, LINE, RECT, DONE; busy = (state != IDLE).
REQ-013 SHALL accept a command only in IDLE; it latches all inputs on the edge where command_valid=1 and moves to the opcode state.
REQ-014 SHALL ignore command_valid while busy (no queueing, no effect on the running command).
REQ-015 CLEAR: SHALL zero one row per cycle, rows 0..7, 8 cycles, then DONE.
REQ-016 PIXEL: SHALL set (x1,y1) in 1 cycle, then DONE.
REQ-017 LINE: SHALL plot Bresenham from (x1,y1) to (x2,y2), both endpoints inclusive, one pixel per cycle; max(|dx|,|dy|)+1 cycles, then DONE.
REQ-018 LINE arithmetic: dx=|x2-x1|, dy=|y2-y1|, sx/sy=+1 if end>=start else -1; err init dx-dy (signed 5-bit); each cycle plot (x,y); if (x,y)==(x2,y2) go DONE; else e2=2*err (signed 6-bit); if e2>=-dy: err-=dy, x+=sx; if e2<=dx: err+=dx, y+=sy.
REQ-019 LINE with (x1,y1)==(x2,y2) SHALL plot exactly one pixel in 1 cycle.
REQ-020 RECT: SHALL scan row-major, y from y1 to y1+h-1 outer, x from x1 to x1+w-1 inner, one position per cycle, w*h cycles, then DONE.
REQ-021 RECT coordinates SHALL use 4-bit sums; positions with x>7 or y>7 consume their cycle without writing (clip, no wrap).
REQ-022 RECT with rect_width=0 or rect_height=0 SHALL write nothing and go to DONE after 1 cycle.
REQ-023 DONE SHALL last exactly 1 cycle with done=1, then IDLE; busy=1 during DONE.
REQ-024 A command accepted at edge N SHALL make its first write visible on fb_row_data after edge N+1.
REQ-025 fb_row_data SHALL reflect writes from the most recent edge (no read latency, no bypass of the pending edge).

Reset
REQ-026 rst=1 SHALL immediately force state=IDLE, busy=0, done=0, framebuffer all zero, internal registers zero.
REQ-027 rst asserted mid-command SHALL abort it with no done pulse; after release the block accepts a new command.
REQ-028 command_valid during rst SHALL be ignored.

Verification
REQ-029 Reset, then PIXEL (3,5) -> row 5 = 8'h08, busy high 2 cycles, done pulses on 2nd cycle after accept.
REQ-030 LINE (0,0)->(7,7) -> rows y = 1<<y, 8 plot cycles + DONE; LINE (7,2)->(0,2) -> row 2 = 8'hFF.
REQ-031 LINE (0,0)->(7,3) -> pixels (0,0),(1,0),(2,1),(3,1),(4,2),(5,2),(6,3),(7,3); 8 plot cycles.
REQ-032 RECT x1=6,y1=6,w=3,h=3 -> rows 6,7 = 8'hC0, other rows unchanged, 9 scan cycles; RECT w=0 -> no change, done after 2 cycles.
REQ-033 Fill screen, then CLEAR -> all rows 8'h00 after 8 cycles; command_valid pulsed during CLEAR has no effect.
REQ-034 rst pulse during RECT w=7,h=7 at 4th cycle -> framebuffer zero, busy=0, no done; next PIXEL (0,0) completes normally.

Source files
------------

// File: rtl/raster_engine.sv
// Raster engine: 8x8 one-bit framebuffer with CLEAR, PIXEL, LINE and RECT commands.
// Commands execute one pixel (or row) per cycle and finish with a one-cycle done pulse.
module raster_engine (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] command,
    input  logic [2:0] x1,
    input  logic [2:0] y1,
    input  logic [2:0] x2,
    input  logic [2:0] y2,
    input  logic [2:0] rect_width,
    input  logic [2:0] rect_height,
    input  logic       command_valid,
    input  logic [2:0] fb_row_sel,
    output logic [7:0] fb_row_data,
    output logic       busy,
    output logic       done
);
    typedef enum logic [2:0] {IDLE, CLEAR, PIXEL, LINE, RECT, DONE} state_t;

    state_t            state;
    logic [7:0]        fb [8];
    logic [3:0]        cx, cy;
    logic [2:0]        ex, ey, rx0, row;
    logic [3:0]        rx_end, ry_end;
    logic [2:0]        dx, dy;
    logic              sx, sy, empty;
    logic signed [4:0] err;

    logic [2:0]        adx, ady;
    logic signed [5:0] e2, ndy, pdx;
    logic              step_x, step_y;
    logic signed [4:0] err_nx;

    assign fb_row_data = fb[fb_row_sel];
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);

    always_comb begin
        adx    = (x2 >= x1) ? x2 - x1 : x1 - x2;
        ady    = (y2 >= y1) ? y2 - y1 : y1 - y2;
        e2     = {err, 1'b0};
        ndy    = -$signed({3'b000, dy});
        pdx    = $signed({3'b000, dx});
        step_x = (e2 >= ndy);
        step_y = (e2 <= pdx);
        err_nx = err
               - (step_x ? $signed({2'b00, dy}) : 5'sd0)
               + (step_y ? $signed({2'b00, dx}) : 5'sd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            for (int i = 0; i < 8; i++) fb[i] <= 8'h00;
            cx     <= 4'd0;
            cy     <= 4'd0;
            ex     <= 3'd0;
            ey     <= 3'd0;
            rx0    <= 3'd0;
            row    <= 3'd0;
            rx_end <= 4'd0;
            ry_end <= 4'd0;
            dx     <= 3'd0;
            dy     <= 3'd0;
            sx     <= 1'b0;
            sy     <= 1'b0;
            empty  <= 1'b0;
            err    <= 5'sd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (command_valid) begin
                        cx     <= {1'b0, x1};
                        cy     <= {1'b0, y1};
                        ex     <= x2;
                        ey     <= y2;
                        rx0    <= x1;
                        row    <= 3'd0;
                        rx_end <= {1'b0, x1} + {1'b0, rect_width} - 4'd1;
                        ry_end <= {1'b0, y1} + {1'b0, rect_height} - 4'd1;
                        dx     <= adx;
                        dy     <= ady;
                        sx     <= (x2 >= x1);
                        sy     <= (y2 >= y1);
                        empty  <= (rect_width == 3'd0) || (rect_height == 3'd0);
                        err    <= $signed({2'b00, adx}) - $signed({2'b00, ady});
                        unique case (command)
                            2'b00:   state <= CLEAR;
                            2'b01:   state <= PIXEL;
                            2'b10:   state <= LINE;
                            default: state <= RECT;
                        endcase
                    end
                end
                CLEAR: begin
                    fb[row] <= 8'h00;
                    row     <= row + 3'd1;
                    if (row == 3'd7) state <= DONE;
                end
                PIXEL: begin
                    fb[cy[2:0]][cx[2:0]] <= 1'b1;
                    state <= DONE;
                end
                LINE: begin
                    fb[cy[2:0]][cx[2:0]] <= 1'b1;
                    if (cx[2:0] == ex && cy[2:0] == ey) begin
                        state <= DONE;
                    end else begin
                        err <= err_nx;
                        if (step_x) cx <= sx ? cx + 4'd1 : cx - 4'd1;
                        if (step_y) cy <= sy ? cy + 4'd1 : cy - 4'd1;
                    end
                end
                RECT: begin
                    if (empty) begin
                        state <= DONE;
                    end else begin
                        // Off-screen positions still take their cycle
                        if (!cx[3] && !cy[3]) fb[cy[2:0]][cx[2:0]] <= 1'b1;
                        if (cx == rx_end) begin
                            if (cy == ry_end) begin
                                state <= DONE;
                            end else begin
                                cx <= {1'b0, rx0};
                                cy <= cy + 4'd1;
                            end
                        end else begin
                            cx <= cx + 4'd1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_raster_engine.sv
// Directed bench for raster_engine: expected latency and framebuffer image are
// queued at issue time and compared when the command completes.
module tb_raster_engine;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] command;
    logic [2:0] x1, y1, x2, y2, rect_width, rect_height;
    logic       command_valid;
    logic [2:0] fb_row_sel;
    logic [7:0] fb_row_data;
    logic       busy, done;

    raster_engine dut (
        .clk(clk), .rst(rst), .command(command),
        .x1(x1), .y1(y1), .x2(x2), .y2(y2),
        .rect_width(rect_width), .rect_height(rect_height),
        .command_valid(command_valid), .fb_row_sel(fb_row_sel),
        .fb_row_data(fb_row_data), .busy(busy), .done(done)
    );

    always #10 clk = ~clk;

    typedef struct {
        int          lat;
        logic [63:0] img;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mfb [8];
    int         checks = 0;
    int         failures = 0;

    function automatic logic [63:0] pack_m();
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[i*8 +: 8] = mfb[i];
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic read_fb(output logic [63:0] v);
        for (int i = 0; i < 8; i++) begin
            fb_row_sel = 3'(i);
            #1;
            v[i*8 +: 8] = fb_row_data;
        end
    endtask

    task automatic issue(input logic [1:0] c, input logic [2:0] a, input logic [2:0] b,
                         input logic [2:0] p, input logic [2:0] q,
                         input logic [2:0] w, input logic [2:0] h, input int lat);
        exp_t e;
        @(negedge clk);
        command = c; x1 = a; y1 = b; x2 = p; y2 = q;
        rect_width = w; rect_height = h;
        command_valid = 1'b1;
        e.lat = lat;
        e.img = pack_m();
        sb.push_back(e);
        @(negedge clk);
        command_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int inject);
        exp_t        e;
        int          n;
        logic        busy_ok;
        logic [63:0] img;
        e = sb.pop_front();
        n = 1;
        busy_ok = 1'b1;
        while (done !== 1'b1 && n < 300) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (n == inject) begin
                command = 2'b01; x1 = 3'd2; y1 = 3'd2;
                command_valid = 1'b1;
            end
            @(negedge clk);
            command_valid = 1'b0;
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(e.lat));
        chk({tag, "_busy_during"}, 64'(busy_ok), 64'd1);
        @(negedge clk);
        chk({tag, "_idle_after"}, {62'd0, busy, done}, 64'd0);
        read_fb(img);
        chk({tag, "_image"}, img, e.img);
    endtask

    task automatic do_reset(input string tag);
        logic [63:0] img;
        @(negedge clk);
        rst = 1'b1;
        command = 2'b01; x1 = 3'd1; y1 = 3'd1;
        command_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        command_valid = 1'b0;
        for (int i = 0; i < 8; i++) mfb[i] = 8'h00;
        @(negedge clk);
        chk({tag, "_busy_done"}, {62'd0, busy, done}, 64'd0);
        read_fb(img);
        chk({tag, "_image"}, img, 64'd0);
    endtask

    initial begin
        logic [63:0] img;
        rst = 1'b1;
        command = 2'b00; x1 = 3'd0; y1 = 3'd0; x2 = 3'd0; y2 = 3'd0;
        rect_width = 3'd0; rect_height = 3'd0;
        command_valid = 1'b0;
        fb_row_sel = 3'd0;
        for (int i = 0; i < 8; i++) mfb[i] = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        do_reset("reset");

        mfb[5] = 8'h08;
        issue(2'b01, 3'd3, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0, 2);
        fb_row_sel = 3'd5;
        #1;
        chk("pixel_not_yet", 64'(fb_row_data), 64'h00);
        wait_done("pixel", 0);

        for (int i = 0; i < 8; i++) mfb[i][i] = 1'b1;
        issue(2'b10, 3'd0, 3'd0, 3'd7, 3'd7, 3'd0, 3'd0, 9);
        wait_done("line_diag", 0);

        mfb[2] = 8'hFF;
        issue(2'b10, 3'd7, 3'd2, 3'd0, 3'd2, 3'd0, 3'd0, 9);
        wait_done("line_horiz_rev", 0);

        mfb[6][4] = 1'b1;
        issue(2'b10, 3'd4, 3'd6, 3'd4, 3'd6, 3'd0, 3'd0, 2);
        wait_done("line_point", 0);

        do_reset("reset2");

        mfb[0] = 8'h03; mfb[1] = 8'h0C; mfb[2] = 8'h30; mfb[3] = 8'hC0;
        issue(2'b10, 3'd0, 3'd0, 3'd7, 3'd3, 3'd0, 3'd0, 9);
        wait_done("line_shallow", 0);

        mfb[6] = 8'hC0; mfb[7] = 8'hC0;
        issue(2'b11, 3'd6, 3'd6, 3'd0, 3'd0, 3'd3, 3'd3, 10);
        wait_done("rect_clip", 0);

        issue(2'b11, 3'd2, 3'd2, 3'd0, 3'd0, 3'd0, 3'd3, 2);
        wait_done("rect_w0", 0);

        issue(2'b11, 3'd1, 3'd4, 3'd0, 3'd0, 3'd5, 3'd0, 2);
        wait_done("rect_h0", 0);

        for (int i = 0; i < 7; i++) mfb[i] = mfb[i] | 8'h7F;
        issue(2'b11, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd7, 50);
        wait_done("rect_7x7", 0);

        for (int i = 1; i < 7; i++) mfb[i] = 8'hFF;
        mfb[7] = 8'hFE;
        issue(2'b11, 3'd1, 3'd1, 3'd0, 3'd0, 3'd7, 3'd7, 50);
        wait_done("rect_7x7_off", 0);

        mfb[0] = 8'hFF;
        issue(2'b01, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 2);
        wait_done("pixel_7_0", 0);

        mfb[7] = 8'hFF;
        issue(2'b01, 3'd0, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 2);
        wait_done("pixel_0_7", 0);

        for (int i = 0; i < 8; i++) mfb[i] = 8'h00;
        issue(2'b00, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 9);
        wait_done("clear_inject", 3);

        issue(2'b11, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd7, 50);
        sb.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy_done", {62'd0, busy, done}, 64'd0);
        read_fb(img);
        chk("abort_image", img, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_no_done", {62'd0, busy, done}, 64'd0);

        mfb[0] = 8'h01;
        issue(2'b01, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 2);
        wait_done("pixel_after_abort", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
